// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_NUM_RD = 2;
   localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;
   localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register plus a registered popcount.
// A reservation beats a writeback to the same register in the same cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wen,
   input  logic [ADDR_W-1:0]      w_addr,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic [(2**ADDR_W)-1:0] busy,
   output logic [ADDR_W:0]        busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_ADDR);

   logic [DEPTH-1:0] r_busy;
   logic [ADDR_W:0]  r_cnt;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [ADDR_W:0]  w_cnt_nxt;

   // Clear first, then set, so a new producer wins over its predecessor's writeback.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wen)
         w_busy_nxt[w_addr] = 1'b0;
      if (rsv_en)
         w_busy_nxt[rsv_addr] = 1'b1;
      if (ZERO_REG != 0)
         w_busy_nxt[W_ZERO] = 1'b0;
      w_cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign busy     = r_busy;
   assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired zero register and busy scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wen,
   input  logic [ADDR_W-1:0]          w_addr,
   input  logic [DATA_W-1:0]          w_data,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic [ADDR_W:0]            busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  w_busy;
   logic              w_wr_ok;

   assign w_wr_ok = wen && !((ZERO_REG != 0) && (w_addr == W_ZERO));

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_wr_ok) begin
         r_regs[w_addr] <= w_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .w_addr   (w_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy     (w_busy),
      .busy_cnt (busy_cnt)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_zero;
      logic              w_fwd_data;
      logic              w_fwd_clr;

      assign w_ra   = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_ra == W_ZERO);

`ifdef REGFILE_MP_BYPASS_EN
      // A same-cycle reservation keeps the registered busy bit; the new one lands next edge.
      assign w_fwd_data = wen && (w_addr == w_ra);
      assign w_fwd_clr  = w_fwd_data && !(rsv_en && (rsv_addr == w_ra));
`else
      assign w_fwd_data = 1'b0;
      assign w_fwd_clr  = 1'b0;
`endif

      assign rd_data[k*DATA_W +: DATA_W] = w_zero     ? {DATA_W{1'b0}} :
                                           w_fwd_data ? w_data : r_regs[w_ra];
      assign rd_busy[k] = w_zero ? 1'b0 : (w_fwd_clr ? 1'b0 : w_busy[w_ra]);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus hand-written reset, bypass and wide-config sequences.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int XDW = 64;
   localparam int XAW = 4;
   localparam int XNR = 3;

   logic             clk;
   logic             rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             wen;
   logic [AW-1:0]    w_addr;
   logic [DW-1:0]    w_data;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;
   logic [AW:0]      busy_cnt;

   logic [XNR*XAW-1:0] x_rd_addr;
   logic [XNR*XDW-1:0] x_rd_data;
   logic [XNR-1:0]     x_rd_busy;
   logic               x_wen;
   logic [XAW-1:0]     x_w_addr;
   logic [XDW-1:0]     x_w_data;
   logic [XAW:0]       x_busy_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [XDW-1:0] exp_q[$];
   logic [XDW-1:0] x_model [16];

   typedef struct {
      logic          wen;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          rsv;
      logic [AW-1:0] ra_rsv;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          b0;
      logic          b1;
      logic [AW:0]   cnt;
   } vec_t;

   vec_t vecs [10];

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wen(wen), .w_addr(w_addr), .w_data(w_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_cnt(busy_cnt)
   );

   regfile_mp #(.DATA_W(XDW), .ADDR_W(XAW), .NUM_RD(XNR), .ZERO_REG(1)) u_dut_x (
      .clk(clk), .rst(rst), .rd_addr(x_rd_addr), .rd_data(x_rd_data), .rd_busy(x_rd_busy),
      .wen(x_wen), .w_addr(x_w_addr), .w_data(x_w_data), .rsv_en(1'b0), .rsv_addr('0),
      .busy_cnt(x_busy_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [XDW-1:0] act, input logic [XDW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic idle();
      wen    = 1'b0;
      rsv_en = 1'b0;
   endtask

   // Drive one cycle of strobes, take the edge, then drop them.
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rs, input logic [AW-1:0] ra);
      @(negedge clk);
      wen = we; w_addr = wa; w_data = wd; rsv_en = rs; rsv_addr = ra;
      @(posedge clk);
      #1 idle();
   endtask

   task automatic chk_ports(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic b0, input logic b1, input logic [AW:0] cnt);
      chk({tag, ".d0"}, XDW'(rd_data[0 +: DW]), XDW'(d0));
      chk({tag, ".d1"}, XDW'(rd_data[DW +: DW]), XDW'(d1));
      chk({tag, ".b0"}, XDW'(rd_busy[0]), XDW'(b0));
      chk({tag, ".b1"}, XDW'(rd_busy[1]), XDW'(b1));
      chk({tag, ".cnt"}, XDW'(busy_cnt), XDW'(cnt));
   endtask

   initial begin
      rst = 1'b0; idle(); w_addr = '0; w_data = '0; rsv_addr = '0; set_rd(5'd0, 5'd5);
      x_wen = 1'b0; x_w_addr = '0; x_w_data = '0; x_rd_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1 chk_ports("reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

      //           wen  wa     wd            rsv  rsv_a  a0     a1     d0            d1            b0    b1    cnt
      vecs[0] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 6'd0};
      vecs[1] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0,  5'd7,  5'd31, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h12345678, 1'b1, 1'b0, 6'd1};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1, 6'd2};
      vecs[4] = '{1'b1, 5'd3,  32'h11112222, 1'b0, 5'd0,  5'd3,  5'd9,  32'h11112222, 32'h0,        1'b0, 1'b1, 6'd1};
      vecs[5] = '{1'b1, 5'd9,  32'h33334444, 1'b1, 5'd9,  5'd9,  5'd3,  32'h33334444, 32'h11112222, 1'b1, 1'b0, 6'd1};
      vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'h33334444, 1'b0, 1'b1, 6'd1};
      vecs[7] = '{1'b1, 5'd20, 32'hAAAA5555, 1'b1, 5'd21, 5'd20, 5'd21, 32'hAAAA5555, 32'h0,        1'b0, 1'b1, 6'd2};
      vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd21, 32'h33334444, 32'h0,        1'b1, 1'b1, 6'd2};
      vecs[9] = '{1'b1, 5'd21, 32'h00005A5A, 1'b1, 5'd22, 5'd21, 5'd22, 32'h00005A5A, 32'h0,        1'b0, 1'b1, 6'd2};

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].ra_rsv);
         set_rd(vecs[i].a0, vecs[i].a1);
         #1 chk_ports($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].b0, vecs[i].b1, vecs[i].cnt);
      end

      // Same-cycle write and reserve of r4: data lands, r4 stays busy.
      step(1'b1, 5'd4, 32'h0BADF00D, 1'b1, 5'd4);
      set_rd(5'd4, 5'd0);
      #1 chk_ports("rsv_wr_r4", 32'h0BADF00D, 32'h0, 1'b1, 1'b0, 6'd3);

      // Writeback to r4 observed in the writeback cycle itself.
      @(negedge clk);
      wen = 1'b1; w_addr = 5'd4; w_data = 32'hA5A5A5A5; set_rd(5'd4, 5'd0);
      #2;
`ifdef REGFILE_MP_BYPASS_EN
      chk("byp_same_cycle.d0", XDW'(rd_data[0 +: DW]), XDW'(32'hA5A5A5A5));
      chk("byp_same_cycle.b0", XDW'(rd_busy[0]), XDW'(1'b0));
`else
      chk("nobyp_same_cycle.d0", XDW'(rd_data[0 +: DW]), XDW'(32'h0BADF00D));
      chk("nobyp_same_cycle.b0", XDW'(rd_busy[0]), XDW'(1'b1));
`endif
      @(posedge clk);
      #1 idle();
      #1 chk_ports("wb_r4_after", 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 6'd2);

      // Writeback to r0 must never leak onto a read port, even combinationally.
      @(negedge clk);
      wen = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF; set_rd(5'd0, 5'd0);
      #2 chk("zero_same_cycle.d0", XDW'(rd_data[0 +: DW]), XDW'(32'h0));
      chk("zero_same_cycle.b0", XDW'(rd_busy[0]), XDW'(1'b0));
      @(posedge clk);
      #1 idle();

      // Re-reserve r4, then write+reserve r4 together: busy stays registered 1.
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      @(negedge clk);
      wen = 1'b1; w_addr = 5'd4; w_data = 32'h5555AAAA; rsv_en = 1'b1; rsv_addr = 5'd4;
      set_rd(5'd4, 5'd9);
      #2;
`ifdef REGFILE_MP_BYPASS_EN
      chk("byp_rsv_same.d0", XDW'(rd_data[0 +: DW]), XDW'(32'h5555AAAA));
`else
      chk("nobyp_rsv_same.d0", XDW'(rd_data[0 +: DW]), XDW'(32'hA5A5A5A5));
`endif
      chk("rsv_same.b0", XDW'(rd_busy[0]), XDW'(1'b1));
      @(posedge clk);
      #1 idle();
      #1 chk_ports("rsv_same_after", 32'h5555AAAA, 32'h33334444, 1'b1, 1'b1, 6'd3);

      // Mid-operation reset with competing strobes.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      set_rd(5'd5, 5'd5);
      #1 chk("pre_reset.r5", XDW'(rd_data[0 +: DW]), XDW'(32'hDEADBEEF));
      @(negedge clk);
      rst = 1'b0; wen = 1'b1; w_addr = 5'd5; w_data = 32'h00012345; rsv_en = 1'b1; rsv_addr = 5'd6;
      @(posedge clk);
      #1 idle();
      rst = 1'b1;
      set_rd(5'd5, 5'd6);
      #1 chk_ports("post_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
      set_rd(5'd7, 5'd4);
      #1 chk_ports("post_reset2", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

      // Wide configuration: fill all 16 registers, read back in random order on 3 ports.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         x_wen = 1'b1; x_w_addr = XAW'(i);
         x_w_data = {32'h0F0F0000 | 32'(i), 32'hC0DE0000 | (32'(i) << 4)};
         x_model[i] = (i == 0) ? '0 : x_w_data;
         @(posedge clk);
         #1 x_wen = 1'b0;
      end
      for (int r = 0; r < 8; r++) begin
         logic [XAW-1:0] a [XNR];
         for (int k = 0; k < XNR; k++) begin
            a[k] = XAW'($urandom_range(0, 15));
            x_rd_addr[k*XAW +: XAW] = a[k];
            exp_q.push_back(x_model[a[k]]);
         end
         #1;
         for (int k = 0; k < XNR; k++)
            chk($sformatf("wide_r%0d_p%0d_a%0d", r, k, a[k]), x_rd_data[k*XDW +: XDW], exp_q.pop_front());
      end
      chk("wide.busy", XDW'(x_rd_busy), XDW'(0));
      chk("wide.cnt", XDW'(x_busy_cnt), XDW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
